// File: rtl/alu_arbiter_pkg.sv
// Arbiter-local constants and the round-robin pick rule.
package alu_arbiter_pkg;

  localparam int unsigned NR_REQ = 2;

  // Sole requester wins; on contention the port not granted last time wins.
  function automatic logic rr_pick(input logic [NR_REQ-1:0] valid, input logic last_grant);
    if (valid == 2'b11) return ~last_grant;
    return valid[1];
  endfunction

endpackage

// File: rtl/ariane_pkg.sv
// Slice of the core's shared package: functional-unit operator, payload and tag width.
package ariane_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [6:0] {
    ADD, SUB, ADDW, SUBW,
    XORL, ORL, ANDL,
    SRA, SRL, SLL, SRLW, SLLW, SRAW,
    LTS, LTU, GES, GEU, EQ, NE,
    SLTS, SLTU
  } fu_op;

  typedef struct packed {
    fu_op             operation;
    logic [XLEN-1:0]  operand_a;
    logic [XLEN-1:0]  operand_b;
  } fu_data_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU: arithmetic/logic/shift result plus branch compare.
module alu
  import ariane_pkg::*;
(
  input  fu_data_t         fu_data_i,
  output logic [XLEN-1:0]  result_o,
  output logic             alu_branch_res_o
);

  logic [XLEN-1:0] a, b;
  logic [31:0]     w_res;
  logic            lt_s, lt_u;

  // Operator decode; word ops compute on the low 32 bits and sign-extend.
  always_comb begin
    a                = fu_data_i.operand_a;
    b                = fu_data_i.operand_b;
    lt_s             = $signed(a) < $signed(b);
    lt_u             = a < b;
    w_res            = 32'h0;
    result_o         = '0;
    alu_branch_res_o = 1'b0;
    unique case (fu_data_i.operation)
      ADD:  result_o = a + b;
      SUB:  result_o = a - b;
      ADDW: begin
        w_res    = a[31:0] + b[31:0];
        result_o = {{32{w_res[31]}}, w_res};
      end
      SUBW: begin
        w_res    = a[31:0] - b[31:0];
        result_o = {{32{w_res[31]}}, w_res};
      end
      XORL: result_o = a ^ b;
      ORL:  result_o = a | b;
      ANDL: result_o = a & b;
      SLL:  result_o = a << b[5:0];
      SRL:  result_o = a >> b[5:0];
      SRA:  result_o = XLEN'($signed(a) >>> b[5:0]);
      SLLW: begin
        w_res    = a[31:0] << b[4:0];
        result_o = {{32{w_res[31]}}, w_res};
      end
      SRLW: begin
        w_res    = a[31:0] >> b[4:0];
        result_o = {{32{w_res[31]}}, w_res};
      end
      SRAW: begin
        w_res    = 32'($signed(a[31:0]) >>> b[4:0]);
        result_o = {{32{w_res[31]}}, w_res};
      end
      SLTS: result_o = {{(XLEN-1){1'b0}}, lt_s};
      SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
      EQ:   alu_branch_res_o = (a == b);
      NE:   alu_branch_res_o = (a != b);
      LTS:  alu_branch_res_o = lt_s;
      LTU:  alu_branch_res_o = lt_u;
      GES:  alu_branch_res_o = ~lt_s;
      GEU:  alu_branch_res_o = ~lt_u;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU, with a one-entry result register.
module alu_arbiter
  import ariane_pkg::*;
  import alu_arbiter_pkg::*;
(
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic [NR_REQ-1:0]                      req_valid_i,
  output logic [NR_REQ-1:0]                      req_ready_o,
  input  fu_data_t [NR_REQ-1:0]                  fu_data_i,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]   trans_id_i,
  output logic                                   result_valid_o,
  input  logic                                   result_ready_i,
  output logic [XLEN-1:0]                        result_o,
  output logic                                   branch_res_o,
  output logic [TRANS_ID_BITS-1:0]               trans_id_o,
  output logic                                   src_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_e;

  out_state_e                 state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic [XLEN-1:0]            result_q, result_d;
  logic                       branch_res_q, branch_res_d;
  logic [TRANS_ID_BITS-1:0]   trans_id_q, trans_id_d;
  logic                       src_q, src_d;

  logic                       grant;
  logic                       can_accept;
  logic                       handshake;
  fu_data_t                   alu_in;
  logic [XLEN-1:0]            alu_result;
  logic                       alu_branch_res;

  // Grant selection and ready; depends only on valids, flush and the output slot.
  always_comb begin
    grant       = rr_pick(req_valid_i, last_grant_q);
    can_accept  = ~flush_i & ((state_q == EMPTY) | result_ready_i);
    req_ready_o = '0;
    if (can_accept) req_ready_o[grant] = req_valid_i[grant];
    handshake   = |req_ready_o;
    alu_in      = fu_data_i[grant];
  end

  alu i_alu (
    .fu_data_i        (alu_in),
    .result_o         (alu_result),
    .alu_branch_res_o (alu_branch_res)
  );

  // Next state: flush empties, handshake fills, drain without refill empties.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    branch_res_d = branch_res_q;
    trans_id_d   = trans_id_q;
    src_d        = src_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (handshake) begin
      state_d = FULL;
    end else if (result_ready_i) begin
      state_d = EMPTY;
    end
    if (handshake) begin
      last_grant_d = grant;
      result_d     = alu_result;
      branch_res_d = alu_branch_res;
      trans_id_d   = trans_id_i[grant];
      src_d        = grant;
    end
  end

  // State and result registers; last_grant resets to 1 so port 0 wins first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      branch_res_q <= 1'b0;
      trans_id_q   <= '0;
      src_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      branch_res_q <= branch_res_d;
      trans_id_q   <= trans_id_d;
      src_q        <= src_d;
    end
  end

  assign result_valid_o = (state_q == FULL);
  assign result_o       = result_q;
  assign branch_res_o   = branch_res_q;
  assign trans_id_o     = trans_id_q;
  assign src_o          = src_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: cycle model at negedge plus directed literal expectations.
module tb_alu_arbiter;
  import ariane_pkg::*;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 flush_i;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready_o;
  fu_data_t [1:0]       fu_data;
  logic [1:0][2:0]      trans_id;
  logic                 result_valid_o;
  logic                 result_ready_i;
  logic [63:0]          result_o;
  logic                 branch_res_o;
  logic [2:0]           trans_id_o;
  logic                 src_o;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .fu_data_i      (fu_data),
    .trans_id_i     (trans_id),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .branch_res_o   (branch_res_o),
    .trans_id_o     (trans_id_o),
    .src_o          (src_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  // Reference ALU from operator semantics.
  function automatic void model_alu(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic br);
    longint sa, sb;
    sa = a;
    sb = b;
    r  = 64'h0;
    br = 1'b0;
    case (op)
      ADD:  r = a + b;
      SUB:  r = a - b;
      ADDW: r = sext32(a + b);
      SUBW: r = sext32(a - b);
      XORL: r = a ^ b;
      ORL:  r = a | b;
      ANDL: r = a & b;
      SLTS: r = (sa < sb) ? 64'd1 : 64'd0;
      SLTU: r = (a < b) ? 64'd1 : 64'd0;
      EQ:   br = (a == b);
      NE:   br = (a != b);
      LTS:  br = (sa < sb);
      LTU:  br = (a < b);
      GES:  br = (sa >= sb);
      GEU:  br = (a >= b);
      default: r = 64'h0;
    endcase
  endfunction

  // Model state: what the output slot holds and who won last.
  logic        m_full, m_full_n;
  logic [63:0] m_res, m_res_n;
  logic        m_br, m_br_n;
  logic [2:0]  m_tag, m_tag_n;
  logic        m_src, m_src_n;
  logic        m_last, m_last_n;

  // Compare DUT against the model and work out the model's next cycle.
  always @(negedge clk_i) begin
    logic        w;
    logic        can;
    logic [1:0]  exp_rdy;
    logic [63:0] r;
    logic        b;
    if (!rst_ni) begin
      m_full_n = 1'b0; m_res_n = 64'h0; m_br_n = 1'b0;
      m_tag_n  = 3'h0; m_src_n = 1'b0;  m_last_n = 1'b1;
    end else begin
      chk("mdl_valid", 64'(result_valid_o), 64'(m_full));
      if (m_full) begin
        chk("mdl_result", result_o, m_res);
        chk("mdl_branch", 64'(branch_res_o), 64'(m_br));
        chk("mdl_tag", 64'(trans_id_o), 64'(m_tag));
        chk("mdl_src", 64'(src_o), 64'(m_src));
      end
      can     = !flush_i && (!m_full || result_ready_i);
      w       = (req_valid == 2'b11) ? !m_last : req_valid[1];
      exp_rdy = (can && req_valid != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
      chk("mdl_ready", 64'(req_ready_o), 64'(exp_rdy));
      m_full_n = m_full; m_res_n = m_res; m_br_n = m_br;
      m_tag_n  = m_tag;  m_src_n = m_src; m_last_n = m_last;
      if (exp_rdy != 2'b00) begin
        model_alu(fu_data[w].operation, fu_data[w].operand_a, fu_data[w].operand_b, r, b);
        m_full_n = 1'b1; m_res_n = r; m_br_n = b;
        m_tag_n  = trans_id[w]; m_src_n = w; m_last_n = w;
      end else if (flush_i || result_ready_i) begin
        m_full_n = 1'b0;
      end
    end
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_full <= 1'b0; m_res <= 64'h0; m_br <= 1'b0;
      m_tag  <= 3'h0; m_src <= 1'b0;  m_last <= 1'b1;
    end else begin
      m_full <= m_full_n; m_res <= m_res_n; m_br <= m_br_n;
      m_tag  <= m_tag_n;  m_src <= m_src_n; m_last <= m_last_n;
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic p, input fu_op op, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] tag);
    fu_data[p].operation = op;
    fu_data[p].operand_a = a;
    fu_data[p].operand_b = b;
    trans_id[p]          = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  logic [63:0] held_res;
  logic [2:0]  held_tag;
  logic        held_src;

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; req_valid = 2'b00; result_ready_i = 1'b0;
    fu_data = '0; trans_id = '0;
    tick; tick;
    chk("rst_valid", 64'(result_valid_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_branch", 64'(branch_res_o), 64'd0);
    chk("rst_tag", 64'(trans_id_o), 64'd0);
    chk("rst_src", 64'(src_o), 64'd0);
    rst_ni = 1'b1;

    // Single ADD on port 0, result one cycle later.
    set_req(1'b0, ADD, 64'd5, 64'd3, 3'd2);
    req_valid = 2'b01; result_ready_i = 1'b1;
    #1 chk("add_ready", 64'(req_ready_o), 64'b01);
    tick;
    req_valid = 2'b00;
    chk("add_valid", 64'(result_valid_o), 64'd1);
    chk("add_result", result_o, 64'd8);
    chk("add_tag", 64'(trans_id_o), 64'd2);
    chk("add_src", 64'(src_o), 64'd0);
    tick;

    // Round-robin under continuous contention, starting fresh from reset.
    rst_ni = 1'b0; tick; rst_ni = 1'b1;
    set_req(1'b0, ADD, 64'd1, 64'd1, 3'd1);
    set_req(1'b1, SUB, 64'd10, 64'd4, 3'd6);
    req_valid = 2'b11; result_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_ready", 64'(req_ready_o), (i % 2 == 1) ? 64'b10 : 64'b01);
      tick;
      chk("rr_src", 64'(src_o), 64'(i % 2));
      chk("rr_result", result_o, (i % 2 == 1) ? 64'd6 : 64'd2);
    end

    // Back-pressure: slot held, both still valid, nothing accepted.
    result_ready_i = 1'b0;
    trans_id[0] = 3'd3; trans_id[1] = 3'd4;
    held_res = result_o; held_tag = trans_id_o; held_src = src_o;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", 64'(req_ready_o), 64'b00);
      tick;
      chk("stall_valid", 64'(result_valid_o), 64'd1);
      chk("stall_result", result_o, held_res);
      chk("stall_tag", 64'(trans_id_o), 64'(held_tag));
      chk("stall_src", 64'(src_o), 64'(held_src));
    end
    result_ready_i = 1'b1;
    #1 chk("resume_ready0", 64'(req_ready_o), 64'b01);
    tick;
    chk("resume_tag0", 64'(trans_id_o), 64'd3);
    chk("resume_src0", 64'(src_o), 64'd0);
    #1 chk("resume_ready1", 64'(req_ready_o), 64'b10);
    tick;
    chk("resume_tag1", 64'(trans_id_o), 64'd4);
    chk("resume_src1", 64'(src_o), 64'd1);
    req_valid = 2'b00;
    tick;

    // Branch compares and word subtract on port 1.
    set_req(1'b1, EQ, 64'h7, 64'h7, 3'd1);
    req_valid = 2'b10;
    #1 chk("eq_ready", 64'(req_ready_o), 64'b10);
    tick;
    chk("eq_branch", 64'(branch_res_o), 64'd1);
    set_req(1'b1, NE, 64'h7, 64'h7, 3'd2);
    tick;
    chk("ne_branch", 64'(branch_res_o), 64'd0);
    set_req(1'b1, SUBW, 64'd0, 64'd1, 3'd3);
    tick;
    chk("subw_result", result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("subw_src", 64'(src_o), 64'd1);
    req_valid = 2'b00;
    tick;

    // Flush while full and draining: no grant, slot empties, winner memory kept.
    set_req(1'b0, ADD, 64'd5, 64'd3, 3'd2);
    req_valid = 2'b01;
    tick;
    req_valid = 2'b11; flush_i = 1'b1;
    #1 chk("flush_ready", 64'(req_ready_o), 64'b00);
    tick;
    flush_i = 1'b0;
    chk("flush_valid", 64'(result_valid_o), 64'd0);
    #1 chk("flush_next_grant", 64'(req_ready_o), 64'b10);
    tick;
    chk("flush_next_src", 64'(src_o), 64'd1);
    req_valid = 2'b00;
    tick;

    // Reset while full: immediate drop, then port 0 wins first contention.
    set_req(1'b0, ADD, 64'd5, 64'd3, 3'd2);
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00; result_ready_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rstmid_valid", 64'(result_valid_o), 64'd0);
    chk("rstmid_result", result_o, 64'd0);
    chk("rstmid_tag", 64'(trans_id_o), 64'd0);
    tick;
    rst_ni = 1'b1;
    req_valid = 2'b11; result_ready_i = 1'b1;
    #1 chk("rstmid_grant", 64'(req_ready_o), 64'b01);
    tick;
    chk("rstmid_src", 64'(src_o), 64'd0);
    chk("rstmid_valid2", 64'(result_valid_o), 64'd1);
    req_valid = 2'b00;
    tick; tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk_i, input, 1, single clock; all state rises on posedge clk_i.
REQ-002 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port flush_i, input, 1: discard held result, block acceptance this cycle.
REQ-004 SHALL have port req_valid_i, input, 2: per-requester operation valid.
REQ-005 SHALL have port req_ready_o, output, 2: per-requester acceptance; at most one bit set.
REQ-006 SHALL have port fu_data_i, input, 2 x fu_data_t: operator, operand_a, operand_b per requester.
REQ-007 SHALL have port trans_id_i, input, 2 x TRANS_ID_BITS: per-requester tag.
REQ-008 SHALL have port result_valid_o, output, 1: registered result available.
REQ-009 SHALL have port result_ready_i, input, 1: consumer takes result.
REQ-010 SHALL have port result_o, output, 64: ALU result of accepted operation.
REQ-011 SHALL have port branch_res_o, output, 1: ALU branch-compare result.
REQ-012 SHALL have port trans_id_o, output, TRANS_ID_BITS: tag of held result.
REQ-013 SHALL have port src_o, output, 1: index of requester that issued held result.

Function
REQ-014 SHALL share one combinational ALU between two requesters; handshake completes on req_valid_i[i] & req_ready_o[i].
REQ-015 SHALL define can_accept = ~flush_i & (~result_valid_o | result_ready_i).
REQ-016 SHALL grant round-robin: one valid requester wins; both valid, winner is the port not equal to last_grant.
REQ-017 SHALL drive req_ready_o[g] = can_accept & req_valid_i[g] for grant g only; other bit 0; ready never depends on result data.
REQ-018 SHALL update last_grant only on a completed handshake; unchanged on idle, stall, or flush.
REQ-019 SHALL mux the granted fu_data_i into the ALU, register result_o, branch_res_o, trans_id_o, src_o on handshake; latency exactly 1 cycle (accept N, result_valid_o in N+1).
REQ-020 SHALL keep a one-entry output register with state EMPTY/FULL: EMPTY->FULL on handshake; FULL->EMPTY on result_ready_i without new handshake; FULL->FULL on drain plus handshake in same cycle (full throughput, one op/cycle).
REQ-021 SHALL hold result_o, branch_res_o, trans_id_o, src_o stable while result_valid_o=1 and result_ready_i=0.
REQ-022 SHALL on flush_i force EMPTY next cycle, assert no req_ready_o that cycle, and keep last_grant; flush wins over a simultaneous drain.
REQ-023 SHALL leave data registers unchanged when no handshake occurs (no gating required for correctness).

Reset
REQ-024 SHALL on rst_ni=0, independent of clock: result_valid_o=0, result_o=0, branch_res_o=0, trans_id_o=0, src_o=0, last_grant=1 (port 0 wins first contention).
REQ-025 SHALL drop any in-flight or held result on reset mid-operation; req_ready_o follows REQ-017 once rst_ni=1.

Structure
REQ-026 SHALL take fu_data_t, fu_op and TRANS_ID_BITS from ariane_pkg; no new package types.
REQ-027 SHALL instantiate exactly one sub-module, alu, unmodified, as the shared datapath.

Verification
REQ-028 SHALL cover: port0 ADD a=5 b=3, tag 2 -> next cycle result_valid_o=1, result_o=8, trans_id_o=2, src_o=0.
REQ-029 SHALL cover: both ports valid 4 cycles, result_ready_i=1 -> grants 0,1,0,1; src_o sequence 0,1,0,1.
REQ-030 SHALL cover: result held, result_ready_i=0 for 3 cycles, both ports valid -> req_ready_o=00, outputs stable; ready high -> resumes next cycle with no lost or duplicated tags.
REQ-031 SHALL cover: port1 EQ a=b=0x7 -> branch_res_o=1; NE same operands -> branch_res_o=0; SUBW a=0 b=1 -> result_o=0xFFFF_FFFF_FFFF_FFFF.
REQ-032 SHALL cover: flush_i with FULL and result_ready_i=1, both valid -> req_ready_o=00, result_valid_o=0 next cycle, last_grant unchanged.
REQ-033 SHALL cover: rst_ni low while FULL -> result_valid_o=0 immediately; first contention after release grants port 0.
